prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// UART program loader: receives bytes, packs little-endian 32-bit words and writes them to instruction memory.
// Optional even-parity framing (8E1) is enabled by defining PROG_LOADER_PARITY_EN.
//
// state      | meaning
// RX_IDLE    | line idle, waiting for a start-bit falling edge
// RX_START   | half-bit wait, glitch check on the start bit
// RX_DATA    | sampling 8 data bits, LSB first
// RX_PARITY  | sampling the even-parity bit (PROG_LOADER_PARITY_EN only)
// RX_STOP    | sampling the stop bit; on a framing error, hold until line is high
// LD_OFF     | idle, core released from reset
// LD_LOAD    | collecting words, core held in reset
// LD_DONE    | terminator received, core released
module prog_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_i,
    input  logic [15:0]       clks_per_bit_i,
    input  logic              uart_rx_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              core_rst_no,
    output logic              done_o,
    output logic              err_o
);

`ifdef PROG_LOADER_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd4
    } rx_state_t;
`endif

    typedef enum logic [1:0] {
        LD_OFF  = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

    logic rx_meta, rx_sync, rx_prev;
    logic prog_meta, prog_sync, prog_prev;
    logic [2:0] arm_q;
    logic prog_rise, rx_fall;

    // arm_q masks the edge detector until the synchronizer has filled after reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            prog_meta <= 1'b0;
            prog_sync <= 1'b0;
            prog_prev <= 1'b0;
            arm_q     <= 3'b000;
        end else begin
            rx_meta   <= uart_rx_i;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            prog_meta <= prog_i;
            prog_sync <= prog_meta;
            prog_prev <= prog_sync;
            arm_q     <= {arm_q[1:0], 1'b1};
        end
    end

    assign prog_rise = arm_q[2] & prog_sync & ~prog_prev;
    assign rx_fall   = rx_prev & ~rx_sync;

    rx_state_t   rx_state, rx_next;
    logic [15:0] cpb_eff, cpb_q, cnt_q;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic        stop_hold;
    logic        tick, stop_eval, frame_bad, byte_valid, frame_err;

    assign cpb_eff = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
    assign tick    = (cnt_q == 16'd0);

`ifdef PROG_LOADER_PARITY_EN
    logic par_bad;
    assign frame_bad = ~rx_sync | par_bad;
`else
    assign frame_bad = ~rx_sync;
`endif

    assign stop_eval  = (rx_state == RX_STOP) & ~stop_hold & tick;
    assign byte_valid = stop_eval & ~frame_bad;
    assign frame_err  = stop_eval & frame_bad;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && bit_idx == 3'd7) begin
`ifdef PROG_LOADER_PARITY_EN
                    rx_next = RX_PARITY;
`else
                    rx_next = RX_STOP;
`endif
                end
            end
`ifdef PROG_LOADER_PARITY_EN
            RX_PARITY: if (tick) rx_next = RX_STOP;
`endif
            RX_STOP: begin
                if ((stop_hold || tick) && rx_sync) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpb_q     <= 16'd2;
            cnt_q     <= 16'd0;
            bit_idx   <= 3'd0;
            shift_q   <= 8'h00;
            stop_hold <= 1'b0;
`ifdef PROG_LOADER_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            if (rx_state != RX_IDLE && !tick) cnt_q <= cnt_q - 16'd1;
            case (rx_state)
                RX_IDLE: begin
                    stop_hold <= 1'b0;
                    if (rx_fall) begin
                        cpb_q <= cpb_eff;
                        cnt_q <= (cpb_eff >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        cnt_q   <= cpb_q - 16'd1;
                        bit_idx <= 3'd0;
`ifdef PROG_LOADER_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        shift_q <= {rx_sync, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        cnt_q   <= cpb_q - 16'd1;
                    end
                end
`ifdef PROG_LOADER_PARITY_EN
                RX_PARITY: begin
                    if (tick) begin
                        par_bad <= rx_sync ^ (^shift_q);
                        cnt_q   <= cpb_q - 16'd1;
                    end
                end
`endif
                RX_STOP: begin
                    if (stop_hold) begin
                        if (rx_sync) stop_hold <= 1'b0;
                    end else if (tick) begin
                        stop_hold <= ~rx_sync;
                    end
                end
                default: ;
            endcase
        end
    end

    ld_state_t         ld_state, ld_next;
    logic [23:0]       word_q;
    logic [1:0]        byte_idx;
    logic [31:0]       full_word;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q, err_q;

    assign full_word = {shift_q, word_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ld_state <= LD_OFF;
        else         ld_state <= ld_next;
    end

    always_comb begin
        ld_next = ld_state;
        if (prog_rise)
            ld_next = LD_LOAD;
        else if (ld_state == LD_LOAD && byte_valid && byte_idx == 2'd3 && full_word == END_WORD)
            ld_next = LD_DONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q   <= 24'h0;
            byte_idx <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (prog_rise) begin
                word_q   <= 24'h0;
                byte_idx <= 2'd0;
                addr_q   <= '0;
                err_q    <= 1'b0;
            end else begin
                if (we_q) begin
                    addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (&addr_q) err_q <= 1'b1;
                end
                if (frame_err) err_q <= 1'b1;
                if (ld_state == LD_LOAD && byte_valid) begin
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_q[7:0]   <= shift_q;
                        2'd1: word_q[15:8]  <= shift_q;
                        2'd2: word_q[23:16] <= shift_q;
                        default: begin
                            if (full_word != END_WORD) begin
                                we_q    <= 1'b1;
                                wdata_q <= full_word;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign err_o       = err_q;
    assign core_rst_no = (ld_state != LD_LOAD);
    assign done_o      = (ld_state == LD_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed UART bytes, expected writes queued and checked by a monitor.
module tb_prog_loader;

    localparam int AW  = 2;
    localparam int CPB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          prog = 1'b0;
    logic [15:0]   cpb = 16'(CPB);
    logic          uart = 1'b1;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          core_rst_n, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+31:0] exp_q[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(AW), .END_WORD(32'h0000_0FFF)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .prog_i         (prog),
        .clks_per_bit_i (cpb),
        .uart_rx_i      (uart),
        .we_o           (we),
        .addr_o         (addr),
        .wdata_o        (wdata),
        .core_rst_no    (core_rst_n),
        .done_o         (done),
        .err_o          (err)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", addr, wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({addr, wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0h data=%h, required addr=%0h data=%h",
                             addr, wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic bit_time();
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        uart = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            uart = b[i];
            bit_time();
        end
`ifdef PROG_LOADER_PARITY_EN
        uart = (^b) ^ par_flip;
        bit_time();
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        uart = stop_bit;
        bit_time();
        uart = 1'b1;
        bit_time();
        bit_time();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1, 1'b0);
    endtask

    task automatic prog_pulse();
        prog = 1'b1;
        repeat (4) @(negedge clk);
        prog = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        logic [31:0] w;
        // reset state, prog held high through deassertion
        prog  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_core_rst_n", 32'(core_rst_n), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_edge_at_deassert", 32'(core_rst_n), 32'd1);
        prog = 1'b0;
        repeat (6) @(negedge clk);

        // basic word then terminator
        prog_pulse();
        check("load_core_rst_n", 32'(core_rst_n), 32'd0);
        check("load_done", 32'(done), 32'd0);
        push_exp(2'd0, 32'h1234_5678);
        send_word(32'h1234_5678);
        check_drained("word1_written");
        check("addr_after_write", 32'(addr), 32'd1);
        check("core_rst_n_loading", 32'(core_rst_n), 32'd0);
        send_word(32'h0000_0FFF);
        check_drained("terminator_no_write");
        check("done_after_term", 32'(done), 32'd1);
        check("core_rst_n_after_term", 32'(core_rst_n), 32'd1);
        check("err_after_term", 32'(err), 32'd0);
        check("wdata_held", wdata, 32'h1234_5678);
        send_byte(8'h11, 1'b1, 1'b0);
        check_drained("byte_in_done_ignored");

        // framing error byte dropped
        prog_pulse();
        check("done_cleared", 32'(done), 32'd0);
        send_byte(8'h55, 1'b0, 1'b0);
        check("err_framing", 32'(err), 32'd1);
        push_exp(2'd0, 32'hDDCC_BBAA);
        send_word(32'hDDCC_BBAA);
        check_drained("word_after_bad_byte");
        check("err_sticky", 32'(err), 32'd1);

        // reset mid-word
        prog_pulse();
        check("err_cleared_by_prog", 32'(err), 32'd0);
        send_byte(8'h99, 1'b1, 1'b0);
        send_byte(8'h88, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_core_rst_n", 32'(core_rst_n), 32'd1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        prog_pulse();
        push_exp(2'd0, 32'h0403_0201);
        send_word(32'h0403_0201);
        check_drained("word_after_reset");

        // address wrap with a 2-bit address
        prog_pulse();
        for (int k = 0; k < 5; k++) begin
            w = 32'hA0B0_C0D0 + 32'(k);
            push_exp(AW'(k), w);
            send_word(w);
            if (k == 2) check("err_before_wrap", 32'(err), 32'd0);
            if (k == 3) check("err_at_wrap", 32'(err), 32'd1);
        end
        check_drained("wrap_writes");
        check("addr_after_fifth", 32'(addr), 32'd1);

`ifdef PROG_LOADER_PARITY_EN
        prog_pulse();
        send_byte(8'h03, 1'b1, 1'b1);
        check("parity_err", 32'(err), 32'd1);
        check_drained("parity_bad_dropped");
        push_exp(2'd0, 32'h0006_0503);
        send_word(32'h0006_0503);
        check_drained("parity_good_word");
`endif

        repeat (20) @(negedge clk);
        check_drained("final_drained");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
